// File: rtl/stall_flush_ctrl_pkg.sv
// Shared core definitions: hazard FSM encoding, default memory timeout and
// the load-use hazard test used by the pipeline control.
package stall_flush_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } fsm_state_t;

    localparam int DEFAULT_TIMEOUT = 255;

    // Execute-stage load whose result the Decode-stage instruction needs now.
    function automatic logic load_use(input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [4:0] rd, input logic load,
                                      input logic regwrite);
        return load & regwrite & (rd != 5'd0) & ((rd == rs1) | (rd == rs2));
    endfunction

endpackage

// File: rtl/stall_flush_ctrl_sat_counter.sv
// Saturating up-counter for pipeline performance statistics.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/stall_flush_ctrl.sv
// Pipeline hazard control: load-use stalls, branch flushes and data-memory
// wait stalls with an optional timeout, plus stall/flush statistics.
module stall_flush_ctrl
    import stall_flush_ctrl_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1D,
    input  logic [4:0]       rs2D,
    input  logic [4:0]       rdE,
    input  logic             loadE,
    input  logic             regwriteE,
    input  logic             pcsrcE,
    input  logic             dmem_reqM,
    input  logic             dmem_readyM,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Wait counter only has to reach TIMEOUT-1, the last waiting cycle.
    localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WW-1:0] TO_LAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    fsm_state_t    state;
    logic [WW-1:0] wcnt;
    logic          lu, mw, timeout_hit;
    logic          s_all, s_fd, f_d, f_e;

    assign lu          = load_use(rs1D, rs2D, rdE, loadE, regwriteE);
    assign mw          = dmem_reqM & ~dmem_readyM;
    assign timeout_hit = (TIMEOUT != 0) && (wcnt == TO_LAST);

    // Priority: memory wait, then taken branch, then load-use.
    always_comb begin
        s_all = 1'b0;
        s_fd  = 1'b0;
        f_d   = 1'b0;
        f_e   = 1'b0;
        if (state == MEM_WAIT) begin
            s_all = ~dmem_readyM;
        end else if (mw) begin
            s_all = 1'b1;
        end else if (pcsrcE) begin
            f_d = 1'b1;
            f_e = 1'b1;
        end else if (lu) begin
            s_fd = 1'b1;
            f_e  = 1'b1;
        end
    end

    assign stallF = rst_n & (s_all | s_fd);
    assign stallD = rst_n & (s_all | s_fd);
    assign stallE = rst_n & s_all;
    assign stallM = rst_n & s_all;
    assign flushD = rst_n & f_d;
    assign flushE = rst_n & f_e;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            wcnt    <= '0;
            mem_err <= 1'b0;
        end else begin
            mem_err <= 1'b0;
            case (state)
                RUN: begin
                    if (mw) begin
                        state <= MEM_WAIT;
                        wcnt  <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_readyM) begin
                        state <= RUN;
                    end else if (timeout_hit) begin
                        state   <= RUN;
                        mem_err <= 1'b1;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stallF),
        .cnt   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flushE),
        .cnt   (flush_cnt)
    );

endmodule

// File: tb/tb_stall_flush_ctrl.sv
// Bench for stall_flush_ctrl: vector table, corner sequences, and random
// traffic against a cycle-level reference model of the hazard rules.
module tb_stall_flush_ctrl;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] rs1D = '0, rs2D = '0, rdE = '0;
    logic       loadE = 1'b0, regwriteE = 1'b0, pcsrcE = 1'b0;
    logic       dmem_reqM = 1'b0, dmem_readyM = 1'b0;

    logic        stallF, stallD, stallE, stallM, flushD, flushE, mem_err;
    logic [15:0] stall_cnt, flush_cnt;
    logic        stallF2, stallD2, stallE2, stallM2, flushD2, flushE2, mem_err2;
    logic [1:0]  stall_cnt2, flush_cnt2;
    logic [5:0]  ctrl, ctrl2;

    assign ctrl  = {stallF, stallD, stallE, stallM, flushD, flushE};
    assign ctrl2 = {stallF2, stallD2, stallE2, stallM2, flushD2, flushE2};

    always #5 clk = ~clk;

    stall_flush_ctrl #(.CNT_W(16), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .rs1D(rs1D), .rs2D(rs2D), .rdE(rdE),
        .loadE(loadE), .regwriteE(regwriteE), .pcsrcE(pcsrcE),
        .dmem_reqM(dmem_reqM), .dmem_readyM(dmem_readyM),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

    stall_flush_ctrl #(.CNT_W(2), .TIMEOUT(TO)) dut2 (
        .clk(clk), .rst_n(rst_n), .rs1D(rs1D), .rs2D(rs2D), .rdE(rdE),
        .loadE(loadE), .regwriteE(regwriteE), .pcsrcE(pcsrcE),
        .dmem_reqM(dmem_reqM), .dmem_readyM(dmem_readyM),
        .stallF(stallF2), .stallD(stallD2), .stallE(stallE2), .stallM(stallM2),
        .flushD(flushD2), .flushE(flushE2), .mem_err(mem_err2),
        .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs1D = '0; rs2D = '0; rdE = '0; loadE = 0; regwriteE = 0;
        pcsrcE = 0; dmem_reqM = 0; dmem_readyM = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic set_lu(input logic [4:0] r);
        rdE = r; rs1D = 5'd1; rs2D = r; loadE = 1; regwriteE = 1;
    endtask

    typedef struct {
        string      name;
        logic [4:0] rs1, rs2, rd;
        logic       ld, rw, pc;
        logic [5:0] exp;
    } vec_t;

    // Reference model state: plain integers, counted in wait cycles.
    bit waiting;
    int nwait, m_sc, m_fc;
    bit m_err, m_err_nxt;

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    initial begin
        vec_t tbl[9];
        tbl[0] = '{"none",       5'd0, 5'd0, 5'd0, 0, 0, 0, 6'b000000};
        tbl[1] = '{"lu_rs1",     5'd3, 5'd7, 5'd3, 1, 1, 0, 6'b110001};
        tbl[2] = '{"lu_rs2",     5'd8, 5'd9, 5'd9, 1, 1, 0, 6'b110001};
        tbl[3] = '{"lu_rd0",     5'd0, 5'd4, 5'd0, 1, 1, 0, 6'b000000};
        tbl[4] = '{"load_norw",  5'd3, 5'd3, 5'd3, 1, 0, 0, 6'b000000};
        tbl[5] = '{"alu_match",  5'd3, 5'd3, 5'd3, 0, 1, 0, 6'b000000};
        tbl[6] = '{"branch",     5'd0, 5'd0, 5'd0, 0, 0, 1, 6'b000011};
        tbl[7] = '{"branch_lu",  5'd6, 5'd2, 5'd6, 1, 1, 1, 6'b000011};
        tbl[8] = '{"lu_nomatch", 5'd1, 5'd2, 5'd4, 1, 1, 0, 6'b000000};

        // Outputs forced low while reset is held, even with hazards asserted.
        rst_n = 1'b0;
        set_lu(5'd5); pcsrcE = 1; dmem_reqM = 1;
        #3;
        chk("reset_ctrl", ctrl, 0);
        chk("reset_cnt", stall_cnt + flush_cnt, 0);
        chk("reset_err", mem_err, 0);
        do_reset();

        // Single load-use hazard: one stall cycle, counted once.
        set_lu(5'd5);
        #1 chk("lu5_ctrl", ctrl, 6'b110001);
        cyc();
        idle();
        #1 chk("lu5_release", ctrl, 0);
        chk("lu5_stall_cnt", stall_cnt, 1);
        chk("lu5_flush_cnt", flush_cnt, 1);

        foreach (tbl[i]) begin
            rs1D = tbl[i].rs1; rs2D = tbl[i].rs2; rdE = tbl[i].rd;
            loadE = tbl[i].ld; regwriteE = tbl[i].rw; pcsrcE = tbl[i].pc;
            #1 chk(tbl[i].name, ctrl, tbl[i].exp);
            cyc();
        end
        idle();
        do_reset();

        // Memory wait: ready low three cycles, then high.
        dmem_reqM = 1; dmem_readyM = 0;
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("memwait_%0d", k), ctrl, 6'b111100);
            cyc();
        end
        dmem_readyM = 1;
        #1 chk("memwait_ready", ctrl, 0);
        cyc();
        idle();
        #1 chk("memwait_run", ctrl, 0);
        chk("memwait_cnt", stall_cnt, 3);
        do_reset();

        // Timeout: four waiting cycles after entry, then error pulse and RUN.
        dmem_reqM = 1; dmem_readyM = 0;
        for (int k = 0; k < 5; k++) begin
            #1 chk($sformatf("to_stall_%0d", k), ctrl, 6'b111100);
            chk($sformatf("to_noerr_%0d", k), mem_err, 0);
            cyc();
        end
        dmem_reqM = 0;
        #1 chk("to_err_pulse", mem_err, 1);
        chk("to_back_run", ctrl, 0);
        cyc();
        chk("to_err_once", mem_err, 0);
        do_reset();

        // Reset in the middle of a wait aborts it without an error.
        dmem_reqM = 1; dmem_readyM = 0;
        cyc(); cyc();
        #2 rst_n = 1'b0;
        #1 chk("rstwait_ctrl", ctrl, 0);
        cyc(); cyc(); cyc(); cyc();
        chk("rstwait_err", mem_err, 0);
        rst_n = 1'b1;
        dmem_reqM = 0;
        #1 chk("rstwait_run", ctrl, 0);
        cyc();
        chk("rstwait_err2", mem_err, 0);
        do_reset();

        // Saturation of a narrow counter.
        set_lu(5'd7);
        repeat (5) cyc();
        idle();
        #1 chk("sat_cnt2", stall_cnt2, 3);
        chk("sat_cnt16", stall_cnt, 5);
        do_reset();

        // Random traffic against the reference model.
        waiting = 0; nwait = 0; m_sc = 0; m_fc = 0; m_err = 0;
        for (int i = 0; i < 600; i++) begin
            logic [5:0] e;
            logic       lu_m, mw_m;
            rs1D = 5'($urandom_range(0, 3));
            rs2D = 5'($urandom_range(0, 3));
            rdE  = 5'($urandom_range(0, 3));
            loadE = 1'($urandom_range(0, 1));
            regwriteE = 1'($urandom_range(0, 3) != 0);
            pcsrcE = 1'($urandom_range(0, 3) == 0);
            dmem_reqM = 1'($urandom_range(0, 4) == 0);
            dmem_readyM = 1'($urandom_range(0, 2) == 0);
            lu_m = loadE && regwriteE && rdE != 0 && (rdE == rs1D || rdE == rs2D);
            mw_m = dmem_reqM && !dmem_readyM;
            if (waiting)     e = dmem_readyM ? 6'b000000 : 6'b111100;
            else if (mw_m)   e = 6'b111100;
            else if (pcsrcE) e = 6'b000011;
            else if (lu_m)   e = 6'b110001;
            else             e = 6'b000000;
            #1;
            chk($sformatf("rnd_ctrl_%0d", i), ctrl, e);
            chk($sformatf("rnd_ctrl2_%0d", i), ctrl2, e);
            chk($sformatf("rnd_err_%0d", i), mem_err, m_err);
            chk($sformatf("rnd_scnt_%0d", i), stall_cnt, min_i(m_sc, 65535));
            chk($sformatf("rnd_fcnt_%0d", i), flush_cnt, min_i(m_fc, 65535));
            chk($sformatf("rnd_scnt2_%0d", i), stall_cnt2, min_i(m_sc, 3));
            chk($sformatf("rnd_fcnt2_%0d", i), flush_cnt2, min_i(m_fc, 3));
            m_sc += e[5];
            m_fc += e[0];
            m_err_nxt = 0;
            if (!waiting) begin
                if (mw_m) begin waiting = 1; nwait = 0; end
            end else begin
                nwait++;
                if (dmem_readyM) waiting = 0;
                else if (nwait == TO) begin waiting = 0; m_err_nxt = 1; end
            end
            cyc();
            m_err = m_err_nxt;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
